// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: drain FSM states, C element type and a ceil-divide
// helper for tile counts.
package gemm_pkg;

    localparam int unsigned ElemWidth = 32;

    typedef logic signed [ElemWidth-1:0] elem_t;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCap,
        StEmit,
        StFin
    } drain_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/gemm_c_drain.sv
// Reads tiled C words back from SRAM C and streams row-major elements.
// Optional running checksum of emitted elements: define GEMM_DRAIN_CHECKSUM_EN.
module gemm_c_drain
    import gemm_pkg::*;
#(
    parameter int unsigned OutDataWidth  = 32,
    parameter int unsigned AddrWidth     = 10,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [SizeAddrWidth-1:0]     M_size_i,
    input  logic [SizeAddrWidth-1:0]     N_size_i,
    output logic [AddrWidth-1:0]         sram_c_addr_o,
    input  logic [OutDataWidth*M*N-1:0]  sram_c_rdata_i,
    output logic [OutDataWidth-1:0]      out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [OutDataWidth-1:0]      checksum_o
);

    localparam int unsigned RowW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned ColW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IdxW  = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int unsigned WordW = OutDataWidth * M * N;

    drain_state_e state_q, state_d;

    logic [SizeAddrWidth-1:0] m_size_q, n_size_q, tn_total_q;
    logic [SizeAddrWidth-1:0] m_q, n_q, tn_q;
    logic [RowW-1:0]          r_q;
    logic [ColW-1:0]          col_q;
    logic [AddrWidth-1:0]     row_base_q;
    logic [WordW-1:0]         word_q;

    logic                     start_acc, xfer, row_end, last_col, last_elem;
    logic [IdxW-1:0]          elem_idx;
    logic [OutDataWidth-1:0]  elems [M*N];

    always_comb begin
        for (int i = 0; i < int'(M * N); i++) begin
            elems[i] = word_q[i*OutDataWidth +: OutDataWidth];
        end
    end

    assign elem_idx  = IdxW'(32'(r_q) * N + 32'(col_q));
    assign row_end   = (n_q == n_size_q - 1'b1);
    assign last_col  = row_end || (col_q == ColW'(N - 1));
    assign last_elem = row_end && (m_q == m_size_q - 1'b1);
    assign xfer      = (state_q == StEmit) && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = (M_size_i == '0 || N_size_i == '0) ? StFin : StRead;
                end
            end
            StRead: state_d = StCap;
            StCap:  state_d = StEmit;
            StEmit: begin
                if (xfer && last_col) begin
                    state_d = last_elem ? StFin : StRead;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counters are frozen on the final element so the address holds after the drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_q   <= '0;
            n_size_q   <= '0;
            tn_total_q <= '0;
            m_q        <= '0;
            n_q        <= '0;
            tn_q       <= '0;
            r_q        <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            word_q     <= '0;
        end else begin
            if (start_acc) begin
                m_size_q   <= M_size_i;
                n_size_q   <= N_size_i;
                tn_total_q <= SizeAddrWidth'(ceil_div(32'(N_size_i), N));
                m_q        <= '0;
                n_q        <= '0;
                tn_q       <= '0;
                r_q        <= '0;
                col_q      <= '0;
                row_base_q <= '0;
            end
            if (state_q == StCap) begin
                word_q <= sram_c_rdata_i;
            end
            if (xfer && !last_elem) begin
                if (last_col) begin
                    col_q <= '0;
                    if (row_end) begin
                        n_q  <= '0;
                        tn_q <= '0;
                        m_q  <= m_q + 1'b1;
                        if (r_q == RowW'(M - 1)) begin
                            r_q        <= '0;
                            row_base_q <= row_base_q + AddrWidth'(tn_total_q);
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end else begin
                        tn_q <= tn_q + 1'b1;
                        n_q  <= n_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                    n_q   <= n_q + 1'b1;
                end
            end
        end
    end

    assign sram_c_addr_o = row_base_q + AddrWidth'(tn_q);
    assign out_valid_o   = (state_q == StEmit);
    assign out_data_o    = out_valid_o ? elems[elem_idx] : '0;
    assign out_last_o    = out_valid_o && last_elem;
    assign busy_o        = (state_q == StRead) || (state_q == StCap) || (state_q == StEmit);
    assign done_o        = (state_q == StFin);

`ifdef GEMM_DRAIN_CHECKSUM_EN
    logic [OutDataWidth-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (start_acc) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q + out_data_o;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_gemm_c_drain.sv
// Self-checking bench for gemm_c_drain: table of drain cases with a scoreboard
// queue, plus hand-written reset-mid-drain sequence.
module tb_gemm_c_drain;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   m_size;
    logic [7:0]   n_size;
    logic [9:0]   addr;
    logic [511:0] rdata;
    logic [31:0]  odata;
    logic         ovalid;
    logic         oready;
    logic         olast;
    logic         busy;
    logic         done;
    logic [31:0]  csum;

    gemm_c_drain dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .M_size_i       (m_size),
        .N_size_i       (n_size),
        .sram_c_addr_o  (addr),
        .sram_c_rdata_i (rdata),
        .out_data_o     (odata),
        .out_valid_o    (ovalid),
        .out_ready_i    (oready),
        .out_last_o     (olast),
        .busy_o         (busy),
        .done_o         (done),
        .checksum_o     (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [511:0] mem [1024];
    always @(posedge clk) rdata <= mem[addr];

    typedef struct {
        int          m;
        int          n;
        bit          rmode;
        bit          hold;
        logic [31:0] base;
        logic [31:0] step;
    } tcase_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   addr_exp[$];
    int   addr_log[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(ovalid), 0);
        chk({tag, "_last"}, 32'(olast), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_data"}, odata, 0);
        chk({tag, "_csum"}, csum, 0);
    endtask

    // Writes the tiled words and builds the expected beat and address streams.
    task automatic prepare(input tcase_t t);
        int tnum;
        int tmn;
        logic [511:0] w;
        int row;
        int col;
        tnum = (t.n + 3) / 4;
        tmn  = (t.m + 3) / 4;
        for (int tm = 0; tm < tmn; tm++) begin
            for (int tn = 0; tn < tnum; tn++) begin
                w = '0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        row = tm * 4 + r;
                        col = tn * 4 + c;
                        if (row < t.m && col < t.n)
                            w[(r*4+c)*32 +: 32] = t.base + t.step * 32'(row * t.n + col);
                        else
                            w[(r*4+c)*32 +: 32] = 32'hDEAD_0000 ^ 32'(row << 8) ^ 32'(col);
                    end
                end
                mem[tm*tnum+tn] = w;
            end
        end
        exp_q.delete();
        addr_exp.delete();
        for (int r = 0; r < t.m; r++) begin
            for (int c = 0; c < t.n; c++) begin
                exp_q.push_back('{t.base + t.step * 32'(r * t.n + c),
                                  (r == t.m - 1) && (c == t.n - 1)});
            end
            for (int tn = 0; tn < tnum; tn++) begin
                if (addr_exp.size() == 0 || addr_exp[$] != (r / 4) * tnum + tn)
                    addr_exp.push_back((r / 4) * tnum + tn);
            end
        end
    endtask

    task automatic run_drain(input tcase_t t);
        int cycles;
        int beats;
        int first_valid;
        int last_cycle;
        int exp_beats;
        bit done_seen;
        bit stall;
        logic [31:0] pd;
        bit pl;
        logic [31:0] sum;
        exp_t e;
        prepare(t);
        exp_beats = exp_q.size();
        addr_log.delete();
        cycles = 0; beats = 0; first_valid = -1; last_cycle = -100;
        done_seen = 0; stall = 0; pd = '0; pl = 0; sum = '0;
        @(negedge clk);
        m_size = 8'(t.m);
        n_size = 8'(t.n);
        start  = 1'b1;
        oready = 1'b1;
        while (!done_seen && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (!t.hold) start = 1'b0;
            m_size = 8'($urandom);
            n_size = 8'($urandom);
            oready = t.rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (addr_log.size() == 0 || addr_log[$] != int'(addr)) addr_log.push_back(int'(addr));
            if (stall) begin
                chk("stall_valid", 32'(ovalid), 1);
                chk("stall_data", odata, pd);
                chk("stall_last", 32'(olast), 32'(pl));
            end
            if (ovalid && first_valid < 0) first_valid = cycles;
            if (done) begin
                done_seen = 1;
                chk("done_cycle", cycles, (exp_beats == 0) ? 1 : last_cycle + 1);
                chk("busy_at_done", 32'(busy), 0);
                start = 1'b0;
            end
            if (ovalid && oready) begin
                beats++;
                sum += odata;
                if (olast) last_cycle = cycles;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(beats), 32'(exp_beats));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", odata, e.data);
                    chk("beat_last", 32'(olast), 32'(e.last));
                end
            end
            stall = ovalid && !oready;
            pd = odata;
            pl = olast;
        end
        if (!done_seen) chk("drain_timeout", 32'(done_seen), 1);
        chk("beat_count", beats, exp_beats);
        chk("left_in_queue", exp_q.size(), 0);
        chk("first_valid_cycle", first_valid, (exp_beats == 0) ? -1 : 3);
`ifdef GEMM_DRAIN_CHECKSUM_EN
        chk("checksum", csum, sum);
`else
        chk("checksum", csum, 0);
`endif
        if (exp_beats > 0) begin
            chk("addr_seq_len", addr_log.size(), addr_exp.size());
            for (int i = 0; i < addr_log.size() && i < addr_exp.size(); i++)
                chk("addr_seq", addr_log[i], addr_exp[i]);
        end
        oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_done", 32'(done), 0);
            chk("post_valid", 32'(ovalid), 0);
        end
    endtask

    tcase_t tbl[9];
    tcase_t t4;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int cyc;
        tbl[0] = '{4, 4, 1'b0, 1'b0, 32'd0, 32'd1};
        tbl[1] = '{5, 6, 1'b0, 1'b0, 32'd100, 32'd3};
        tbl[2] = '{4, 4, 1'b1, 1'b0, 32'd0, 32'd1};
        tbl[3] = '{3, 9, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd5};
        tbl[4] = '{1, 1, 1'b0, 1'b0, 32'd7, 32'd1};
        tbl[5] = '{8, 3, 1'b1, 1'b1, 32'd1000, 32'd1};
        tbl[6] = '{0, 7, 1'b0, 1'b1, 32'd0, 32'd1};
        tbl[7] = '{6, 0, 1'b0, 1'b0, 32'd0, 32'd1};
        tbl[8] = '{1, 2, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0002};
        t4 = tbl[0];

        rst_n = 1'b0; start = 1'b0; m_size = '0; n_size = '0; oready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_drain(tbl[i]);

        prepare(t4);
        @(negedge clk);
        m_size = 8'd4; n_size = 8'd4; start = 1'b1; oready = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            #1;
            if (ovalid && oready) beats++;
        end
        chk("rst_mid_beats", beats, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        #1;
        check_idle("rst_hold");
        rst_n = 1'b1;
        run_drain(t4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gemm_c_drain.md
# gemm_c_drain

Read-side drain for the GEMM output memory. After the accelerator has written matrix C into SRAM C as tiled words (one M×N tile of OutDataWidth results per word), this block reads the tiles back. It emits the matrix as a row-major element stream over a valid/ready handshake, discarding padding in partial edge tiles. It sits between `i_sram_c` (read port) and the host/DMA side, and turns the tiled layout the core produces back into plain row-major C.

## Interface
Parameters:
- OutDataWidth, 32, width of one C element (signed)
- AddrWidth, 10, SRAM C address width
- SizeAddrWidth, 8, width of matrix size inputs
- M, 4, tile rows per SRAM word
- N, 4, tile columns per SRAM word

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin drain; sampled only in IDLE
- M_size_i  in  SizeAddrWidth  matrix rows M_i; latched on accepted start
- N_size_i  in  SizeAddrWidth  matrix columns N_i; latched on accepted start
- sram_c_addr_o  out  AddrWidth  SRAM C read address
- sram_c_rdata_i  in  OutDataWidth*M*N  SRAM C read data, valid one cycle after address
- out_data_o  out  OutDataWidth  current element
- out_valid_o  out  1  element valid
- out_ready_i  in  1  consumer ready
- out_last_o  out  1  marks element C[M_i-1][N_i-1]
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse when the drain completes
- checksum_o  out  OutDataWidth  running sum of emitted elements (see Configuration)

## Operation
- Tile layout: TN = ceil(N_i/N). Tile (tm,tn) is at address tm*TN + tn. Element (r,c) of a tile is at bits [(r*N+c)*OutDataWidth +: OutDataWidth].
- Output order: for m in 0..M_i-1, for n in 0..N_i-1, emit C[m][n]. Each tile word is read once per tile row (M reads per tile). Only columns n < N_i are emitted. Rows are bounded by M_i.
- FSM states:
  - IDLE: on start_i, latch sizes and go to READ. If M_i==0 or N_i==0, go to FIN instead.
  - READ: drive the address for (m/M, tn). Next state is CAP.
  - CAP: capture sram_c_rdata_i into the word register. Next state is EMIT.
  - EMIT: emit columns tn*N .. min(tn*N+N, N_i)-1 of tile row m%M.
    - After the last column handshake, advance tn. At the end of a row, advance m and reset tn to 0.
    - Go to READ, or to FIN after the last element.
  - FIN: pulse done_o, then go to IDLE.
- Handshake:
  - An element transfers when out_valid_o && out_ready_i.
  - While valid is high and ready is low, out_data_o and out_last_o stay stable.
  - Valid never drops without a transfer.
- start_i is ignored when not in IDLE. Sizes are held internally, so size inputs may change after start.
- Address arithmetic is unsigned and truncated to AddrWidth. Callers keep ceil(M_i/M)*TN ≤ 2^AddrWidth.

## Timing
- Reset values:
  - state IDLE
  - sram_c_addr_o 0
  - out_data_o 0
  - out_valid_o 0
  - out_last_o 0
  - busy_o 0
  - done_o 0
  - checksum_o 0
  - all counters 0
- Reset asserted mid-drain returns the block to IDLE immediately. No done_o pulse is produced.
- Start accepted at edge E0. sram_c_addr_o is valid after E0, the capture happens at E2, and out_valid_o first rises after E2.
- Each word costs 2 bubble cycles (READ, CAP) before its elements stream, one per cycle when ready is held high.
- done_o pulses in the cycle after the out_last_o handshake. busy_o falls in that same cycle.
- With a zero size: done_o is high the cycle after start, and no beats are emitted.
- A new start is accepted in the cycle after done_o.

## Configuration
- GEMM_DRAIN_CHECKSUM_EN defined:
  - checksum_o accumulates the sum of every transferred element, modulo 2^OutDataWidth.
  - It clears on accepted start and holds its final value after done.
- GEMM_DRAIN_CHECKSUM_EN not defined: checksum_o is tied to 0 and no accumulator is synthesized.

## Structure
- Shared package gemm_pkg holds:
  - the drain state enum (IDLE, READ, CAP, EMIT, FIN)
  - the element type logic signed [OutDataWidth-1:0]
  - a ceil-divide function used for TN
- No sub-module is required. The word-register element selector may be split into gemm_tile_select (word plus row/col in, element out) if reused by the core.

## Test plan
- M_i=N_i=4, single tile word holding values 0..15 → 16 beats with data 0..15 in order. out_last_o is on beat 16, and done_o pulses the next cycle.
- M_i=5, N_i=6 (TN=2, four words at addresses 0..3) → 30 beats in row-major order. Padding elements of partial tiles never appear. Address sequence is 0,1,0,1,0,1,0,1,2,3.
- 4×4 case with out_ready_i toggling pseudo-randomly → same 16 values. out_data_o is stable during every stall, and valid never drops without a transfer.
- M_i=0, N_i=7 → no out_valid_o, done_o on the cycle after start. start_i held high during a busy drain → no restart and no extra beats.
- rst_ni pulled low after beat 5 of a 4×4 drain → all outputs return to reset values immediately. A fresh start then replays beats 1..16 correctly.
- With GEMM_DRAIN_CHECKSUM_EN, the 4×4 tile of 0..15 gives checksum_o=120 after done. A tile containing 0x7FFFFFFF and 1 wraps to 0x80000000.
